// File: rtl/hex_segment_monitor.sv
// Reader side of the 7-segment encoder: debounces the active-low HEX pattern,
// decodes stable glyphs back to 5-bit codes and reports them over valid/ready.
module hex_segment_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] HEX,
  input  logic       ready,
  input  logic       clear,
  output logic [4:0] BINARY,
  output logic       valid,
  output logic       err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {TRACK = 1'b0, PEND = 1'b1} state_t;

  state_t           r_state;
  logic [6:0]       r_sample;
  logic [6:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic [4:0]       r_binary;
  logic             r_err;
  logic             r_overrun;

  logic             w_diff;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_stable;
  logic             w_event;
  logic             w_new;
  logic             w_report;
  logic             w_drop;
  logic [5:0]       w_dec;

  // Map a glyph to {err, code}; unknown glyphs report 1E with err.
  function automatic logic [5:0] decode(input logic [6:0] pat);
    logic [5:0] res;
    case (pat)
      7'h40:   res = {1'b0, 5'h00};
      7'h79:   res = {1'b0, 5'h01};
      7'h24:   res = {1'b0, 5'h02};
      7'h30:   res = {1'b0, 5'h03};
      7'h19:   res = {1'b0, 5'h04};
      7'h12:   res = {1'b0, 5'h05};
      7'h02:   res = {1'b0, 5'h06};
      7'h78:   res = {1'b0, 5'h07};
      7'h00:   res = {1'b0, 5'h08};
      7'h18:   res = {1'b0, 5'h09};
      7'h08:   res = {1'b0, 5'h0A};
      7'h03:   res = {1'b0, 5'h0B};
      7'h46:   res = {1'b0, 5'h0C};
      7'h21:   res = {1'b0, 5'h0D};
      7'h06:   res = {1'b0, 5'h0E};
      7'h0E:   res = {1'b0, 5'h0F};
      7'h3F:   res = {1'b0, 5'h1A};
      7'h7F:   res = {1'b0, 5'h1F};
      default: res = {1'b1, 5'h1E};
    endcase
    return res;
  endfunction

  assign w_diff     = (HEX != r_sample);
  assign w_cnt_next = w_diff ? CNT_W'(1)
                    : ((r_cnt == STABLE_MAX) ? r_cnt : r_cnt + CNT_W'(1));
  assign w_stable   = (w_cnt_next == STABLE_MAX);
  // Fires once per pattern: on the edge the counter first reaches the threshold.
  assign w_event    = w_stable && (w_diff || (r_cnt != STABLE_MAX));
  assign w_new      = r_first || (HEX != r_last);
  // While idle a saturated, unreported glyph (dropped earlier) is picked up too.
  assign w_report   = w_new && ((r_state == TRACK) ? w_stable : w_event);
  assign w_drop     = (r_state == PEND) && !ready && w_report;
  assign w_dec      = decode(HEX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TRACK;
      r_sample  <= 7'h7F;
      r_last    <= 7'h7F;
      r_cnt     <= '0;
      r_first   <= 1'b1;
      r_binary  <= 5'h1F;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sample <= HEX;
      r_cnt    <= w_cnt_next;
      case (r_state)
        TRACK: begin
          if (w_report) begin
            r_binary <= w_dec[4:0];
            r_err    <= w_dec[5];
            r_last   <= HEX;
            r_first  <= 1'b0;
            r_state  <= PEND;
          end
        end
        PEND: begin
          if (ready) begin
            if (w_report) begin
              r_binary <= w_dec[4:0];
              r_err    <= w_dec[5];
              r_last   <= HEX;
              r_first  <= 1'b0;
            end else begin
              r_state <= TRACK;
            end
          end
        end
        default: r_state <= TRACK;
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clear) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign BINARY  = r_binary;
  assign valid   = (r_state == PEND);
  assign err     = r_err;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_hex_segment_monitor.sv
// Self-checking bench for hex_segment_monitor: decode table, directed corner
// sequences, a STABLE_CYCLES=1 instance and randomized traffic against a model.
module tb_hex_segment_monitor;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] hex;
  logic       ready;
  logic       clear;
  logic [4:0] bin;
  logic       valid;
  logic       err;
  logic       ovr;

  logic [6:0] hex1;
  logic [4:0] bin1;
  logic       valid1;
  logic       err1;
  logic       ovr1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hex_segment_monitor #(.STABLE_CYCLES(S), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .HEX(hex), .ready(ready), .clear(clear),
    .BINARY(bin), .valid(valid), .err(err), .overrun(ovr)
  );

  hex_segment_monitor #(.STABLE_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .HEX(hex1), .ready(1'b1), .clear(1'b0),
    .BINARY(bin1), .valid(valid1), .err(err1), .overrun(ovr1)
  );

  typedef struct {
    logic [6:0] hex;
    logic [4:0] bin;
    logic       err;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait a bounded number of edges for a report and check its contents.
  task automatic expect_report(input string name, input logic [4:0] eb, input logic ee,
                               input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (valid) begin
        found = 1;
        chk({name, "_bin"}, 32'(bin), 32'(eb));
        chk({name, "_err"}, 32'(err), 32'(ee));
      end
    end
    if (!found) chk({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  // Reference model: history of sampled patterns plus report bookkeeping.
  logic [6:0] mq[$];
  bit         m_pend, m_err, m_ovr, m_first;
  logic [4:0] m_bin;
  logic [6:0] m_last;

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 18; i++)
      if (vecs[i].hex == p) return {vecs[i].err, vecs[i].bin};
    return {1'b1, 5'h1E};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_err = 0; m_ovr = 0; m_first = 1;
    m_bin = 5'h1F; m_last = 7'h7F;
  endtask

  task automatic model_step(input logic [6:0] h, input logic rdy, input logic clr);
    bit all_eq, evt, fresh, rep, set_ovr;
    logic [5:0] d;
    mq.push_back(h);
    if (mq.size() > S + 1) void'(mq.pop_front());
    all_eq = (mq.size() >= S);
    for (int i = 0; i < int'(S); i++)
      if (mq[mq.size() - 1 - i] != h) all_eq = 0;
    evt   = all_eq && (mq.size() == S || mq[0] != h);
    fresh = m_first || (h != m_last);
    d     = ref_decode(h);
    set_ovr = 0;
    if (!m_pend) rep = all_eq && fresh;
    else         rep = evt && fresh;
    if (!m_pend) begin
      if (rep) begin m_bin = d[4:0]; m_err = d[5]; m_last = h; m_first = 0; m_pend = 1; end
    end else if (rdy) begin
      if (rep) begin m_bin = d[4:0]; m_err = d[5]; m_last = h; m_first = 0; end
      else m_pend = 0;
    end else if (rep) begin
      set_ovr = 1;
    end
    if (set_ovr) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  initial begin
    int cnt;
    logic [4:0] first_bin;
    vecs[0]  = '{7'h40, 5'h00, 1'b0};  vecs[1]  = '{7'h24, 5'h02, 1'b0};
    vecs[2]  = '{7'h0E, 5'h0F, 1'b0};  vecs[3]  = '{7'h3F, 5'h1A, 1'b0};
    vecs[4]  = '{7'h7F, 5'h1F, 1'b0};  vecs[5]  = '{7'h79, 5'h01, 1'b0};
    vecs[6]  = '{7'h30, 5'h03, 1'b0};  vecs[7]  = '{7'h19, 5'h04, 1'b0};
    vecs[8]  = '{7'h02, 5'h06, 1'b0};  vecs[9]  = '{7'h78, 5'h07, 1'b0};
    vecs[10] = '{7'h00, 5'h08, 1'b0};  vecs[11] = '{7'h18, 5'h09, 1'b0};
    vecs[12] = '{7'h08, 5'h0A, 1'b0};  vecs[13] = '{7'h03, 5'h0B, 1'b0};
    vecs[14] = '{7'h46, 5'h0C, 1'b0};  vecs[15] = '{7'h21, 5'h0D, 1'b0};
    vecs[16] = '{7'h06, 5'h0E, 1'b0};  vecs[17] = '{7'h12, 5'h05, 1'b0};
    vecs[18] = '{7'h2F, 5'h1E, 1'b1};  vecs[19] = '{7'h23, 5'h1E, 1'b1};

    rst_n = 1'b0; hex = 7'h40; ready = 1'b1; clear = 1'b0; hex1 = 7'h7F;
    #23;
    chk("rst_bin", 32'(bin), 32'h1F);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);

    // First report lands exactly STABLE_CYCLES edges after reset release.
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i < int'(S); i++) begin
      tick();
      chk($sformatf("startup_early_%0d", i), 32'(valid), 32'h0);
    end
    tick();
    chk("startup_valid", 32'(valid), 32'h1);
    chk("startup_bin", 32'(bin), 32'h00);
    chk("startup_err", 32'(err), 32'h0);
    tick();
    chk("startup_pulse", 32'(valid), 32'h0);

    // Short glitch and return of the same glyph gives only one report.
    cnt = 0; first_bin = 5'h1F;
    hex = 7'h79;
    for (int i = 0; i < 10; i++) begin tick(); if (valid) begin cnt++; if (cnt == 1) first_bin = bin; end end
    hex = 7'h24;
    for (int i = 0; i < 2; i++) begin tick(); if (valid) cnt++; end
    hex = 7'h79;
    for (int i = 0; i < 10; i++) begin tick(); if (valid) cnt++; end
    chk("glitch_count", 32'(cnt), 32'd1);
    chk("glitch_bin", 32'(first_bin), 32'h01);

    // Decode table, ready always high.
    for (int v = 0; v < 20; v++) begin
      hex = vecs[v].hex;
      expect_report($sformatf("dec_%02h", vecs[v].hex), vecs[v].bin, vecs[v].err, 12);
      for (int i = 0; i < 6; i++) begin
        tick();
        if (valid) chk($sformatf("dec_dup_%02h", vecs[v].hex), 32'(valid), 32'h0);
      end
    end

    // Overrun: second glyph while first is pending, then drain and clear.
    ready = 1'b0; hex = 7'h19;
    expect_report("ovr_first", 5'h04, 1'b0, 12);
    for (int i = 0; i < 4; i++) tick();
    hex = 7'h02;
    for (int i = 0; i < 8; i++) tick();
    chk("ovr_valid_held", 32'(valid), 32'h1);
    chk("ovr_bin_held", 32'(bin), 32'h04);
    chk("ovr_set", 32'(ovr), 32'h1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("ovr_handshake", 32'(valid), 32'h0);
    expect_report("ovr_redeliver", 5'h06, 1'b0, 3);
    chk("ovr_sticky", 32'(ovr), 32'h1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("ovr_clear", 32'(ovr), 32'h0);
    hex = 7'h19;
    for (int i = 0; i < 6; i++) tick();
    chk("ovr_reset_pre", 32'(ovr), 32'h1);

    // STABLE_CYCLES=1 instance: every change reports on its own edge.
    hex1 = 7'h40; tick();
    chk("s1_v0", 32'(valid1), 32'h1); chk("s1_b0", 32'(bin1), 32'h00);
    hex1 = 7'h79; tick();
    chk("s1_v1", 32'(valid1), 32'h1); chk("s1_b1", 32'(bin1), 32'h01);
    hex1 = 7'h23; tick();
    chk("s1_b2", 32'(bin1), 32'h1E); chk("s1_e2", 32'(err1), 32'h1);
    tick();
    chk("s1_idle", 32'(valid1), 32'h0);

    // Asynchronous reset while a report is pending.
    chk("areset_pre", 32'(valid), 32'h1);
    #2 rst_n = 1'b0; #1;
    chk("areset_valid", 32'(valid), 32'h0);
    chk("areset_err", 32'(err), 32'h0);
    chk("areset_ovr", 32'(ovr), 32'h0);
    chk("areset_bin", 32'(bin), 32'h1F);

    // Randomized traffic against the model.
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    begin
      int hold = 0;
      for (int n = 0; n < 3000; n++) begin
        if (hold == 0) begin
          hex  = vecs[$urandom_range(0, 19)].hex;
          hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 12));
        end
        hold--;
        ready = ($urandom_range(0, 3) != 0);
        clear = ($urandom_range(0, 7) == 0);
        tick();
        model_step(hex, ready, clear);
        chk("rnd_valid", 32'(valid), 32'(m_pend));
        chk("rnd_ovr", 32'(ovr), 32'(m_ovr));
        if (m_pend) begin
          chk("rnd_bin", 32'(bin), 32'(m_bin));
          chk("rnd_err", 32'(err), 32'(m_err));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
